// File: rtl/fir_pkg.sv
// Shared constants, coefficient table and FSM encoding for the symmetric FIR MAC.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fir_pkg;

  localparam int C_NTAPS  = 12;
  localparam int C_DATA_W = 16;
  localparam int C_CNT_W  = 4;

  // Half of a 24-tap symmetric low-pass, ordered to match iFirSum1st..12th.
  // The outer taps are negative and the taps toward the centre are positive.
  localparam logic signed [C_DATA_W-1:0] C_COEF [C_NTAPS] = '{
    -16'sd50,  -16'sd160,  -16'sd296,  -16'sd210,
     16'sd330,  16'sd1180,  16'sd2360,  16'sd3590,
     16'sd4700, 16'sd5560,  16'sd6120,  16'sd6400
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    MAC   = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/fir_mac_unit.sv
// Signed 16x16 multiplier feeding a wide accumulator with clear and enable.
// Latency: one clock from operands to updated accumulator.
// Backpressure: none; the caller sequences clr/en.
//
// Ports: iClk_12M/iRsn clock and async active-low reset; clr zeroes the
// accumulator (wins over en); en adds sample*coef; acc is the running sum.
module fir_mac_unit
  import fir_pkg::*;
#(
  parameter int P_ACC_W = 36
) (
  input  logic                       iClk_12M,
  input  logic                       iRsn,
  input  logic                       clr,
  input  logic                       en,
  input  logic signed [C_DATA_W-1:0] sample,
  input  logic signed [C_DATA_W-1:0] coef,
  output logic signed [P_ACC_W-1:0]  acc
);

  logic signed [2*C_DATA_W-1:0] prod;

  // Widen both operands first so the product is the full signed 32-bit result.
  assign prod = (2*C_DATA_W)'(sample) * (2*C_DATA_W)'(coef);

  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + P_ACC_W'(prod);
    end
  end

endmodule

// File: rtl/sym_fir_mac.sv
// Symmetric FIR output stage: snapshots 12 pre-added tap sums and MACs them serially.
// Latency: trigger sampled at edge T gives oFirValid in the cycle after edge T+14.
// Backpressure: none; a trigger while busy is dropped and flagged on oOverrun.
//
// Ports: iClk_12M clock, iRsn async active-low reset, iEnSample_600k/iEnDelay
// trigger qualifiers, iFirSum1st..12th tap sums, oFirOut/oFirValid result,
// oBusy computation in progress, oOverrun sticky dropped-trigger flag.
module sym_fir_mac
  import fir_pkg::*;
#(
  parameter int P_ACC_W     = 36,
  parameter int P_OUT_SHIFT = 4
) (
  input  logic                       iClk_12M,
  input  logic                       iRsn,
  input  logic                       iEnSample_600k,
  input  logic                       iEnDelay,
  input  logic signed [C_DATA_W-1:0] iFirSum1st,
  input  logic signed [C_DATA_W-1:0] iFirSum2nd,
  input  logic signed [C_DATA_W-1:0] iFirSum3rd,
  input  logic signed [C_DATA_W-1:0] iFirSum4th,
  input  logic signed [C_DATA_W-1:0] iFirSum5th,
  input  logic signed [C_DATA_W-1:0] iFirSum6th,
  input  logic signed [C_DATA_W-1:0] iFirSum7th,
  input  logic signed [C_DATA_W-1:0] iFirSum8th,
  input  logic signed [C_DATA_W-1:0] iFirSum9th,
  input  logic signed [C_DATA_W-1:0] iFirSum10th,
  input  logic signed [C_DATA_W-1:0] iFirSum11th,
  input  logic signed [C_DATA_W-1:0] iFirSum12th,
  output logic signed [C_DATA_W-1:0] oFirOut,
  output logic                       oFirValid,
  output logic                       oBusy,
  output logic                       oOverrun
);

  localparam logic signed [P_ACC_W-1:0] C_SAT_MAX = P_ACC_W'(32767);
  localparam logic signed [P_ACC_W-1:0] C_SAT_MIN = -P_ACC_W'(32768);

  state_t                      state, state_nxt;
  logic                        trig;
  logic                        latch_en, mac_en, done_en;
  logic [C_CNT_W-1:0]          tap_cnt;
  logic signed [C_DATA_W-1:0]  sums_in [C_NTAPS];
  logic signed [C_DATA_W-1:0]  snap    [C_NTAPS];
  logic signed [C_DATA_W-1:0]  mac_sample, mac_coef;
  logic signed [P_ACC_W-1:0]   acc, acc_shr;
  logic signed [C_DATA_W-1:0]  sat_val;

  assign trig  = iEnSample_600k & iEnDelay;
  assign oBusy = (state != IDLE);

  always_comb begin
    sums_in[0]  = iFirSum1st;
    sums_in[1]  = iFirSum2nd;
    sums_in[2]  = iFirSum3rd;
    sums_in[3]  = iFirSum4th;
    sums_in[4]  = iFirSum5th;
    sums_in[5]  = iFirSum6th;
    sums_in[6]  = iFirSum7th;
    sums_in[7]  = iFirSum8th;
    sums_in[8]  = iFirSum9th;
    sums_in[9]  = iFirSum10th;
    sums_in[10] = iFirSum11th;
    sums_in[11] = iFirSum12th;
  end

  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    latch_en  = 1'b0;
    mac_en    = 1'b0;
    done_en   = 1'b0;
    case (state)
      IDLE: begin
        if (trig) state_nxt = LATCH;
      end
      LATCH: begin
        latch_en  = 1'b1;
        state_nxt = MAC;
      end
      MAC: begin
        mac_en = 1'b1;
        if (tap_cnt == C_CNT_W'(C_NTAPS - 1)) state_nxt = DONE;
      end
      DONE: begin
        done_en   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The snapshot is taken one clock after the trigger edge, so it sees the
  // delay chain after its shift; later chain movement cannot disturb the MAC.
  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      for (int k = 0; k < C_NTAPS; k++) snap[k] <= '0;
      tap_cnt <= '0;
    end else if (latch_en) begin
      for (int k = 0; k < C_NTAPS; k++) snap[k] <= sums_in[k];
      tap_cnt <= '0;
    end else if (mac_en) begin
      tap_cnt <= tap_cnt + 1'b1;
    end
  end

  always_comb begin
    mac_sample = '0;
    mac_coef   = '0;
    if (mac_en) begin
      mac_sample = snap[tap_cnt];
      mac_coef   = C_COEF[tap_cnt];
    end
  end

  fir_mac_unit #(
    .P_ACC_W (P_ACC_W)
  ) u_mac (
    .iClk_12M (iClk_12M),
    .iRsn     (iRsn),
    .clr      (latch_en),
    .en       (mac_en),
    .sample   (mac_sample),
    .coef     (mac_coef),
    .acc      (acc)
  );

  // Arithmetic shift floors toward minus infinity; clamp only at the output.
  assign acc_shr = acc >>> P_OUT_SHIFT;

  always_comb begin
    if (acc_shr > C_SAT_MAX) begin
      sat_val = 16'sh7FFF;
    end else if (acc_shr < C_SAT_MIN) begin
      sat_val = 16'sh8000;
    end else begin
      sat_val = acc_shr[C_DATA_W-1:0];
    end
  end

  // The result register loads on the edge that leaves DONE, so the valid
  // pulse coincides with the first IDLE cycle.
  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      oFirOut   <= '0;
      oFirValid <= 1'b0;
      oOverrun  <= 1'b0;
    end else begin
      oFirValid <= done_en;
      if (done_en) oFirOut <= sat_val;
      if (trig && (state != IDLE)) oOverrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sym_fir_mac.sv
`timescale 1ns/1ps
module tb_sym_fir_mac;

  logic               iClk_12M = 1'b0;
  logic               iRsn = 1'b1;
  logic               iEnSample_600k = 1'b0;
  logic               iEnDelay = 1'b1;
  logic signed [15:0] sums [12];
  logic signed [15:0] oFirOut;
  logic               oFirValid, oBusy, oOverrun;

  int checks = 0;
  int failures = 0;
  int nvalid = 0;
  bit cmp_en = 1'b0;

  // Filter design coefficients, ordered tap 1st..12th.
  localparam int COEF [12] = '{-50, -160, -296, -210, 330, 1180,
                               2360, 3590, 4700, 5560, 6120, 6400};

  always #5 iClk_12M = ~iClk_12M;

  sym_fir_mac #(.P_ACC_W(36), .P_OUT_SHIFT(4)) dut (
    .iClk_12M       (iClk_12M),
    .iRsn           (iRsn),
    .iEnSample_600k (iEnSample_600k),
    .iEnDelay       (iEnDelay),
    .iFirSum1st     (sums[0]),
    .iFirSum2nd     (sums[1]),
    .iFirSum3rd     (sums[2]),
    .iFirSum4th     (sums[3]),
    .iFirSum5th     (sums[4]),
    .iFirSum6th     (sums[5]),
    .iFirSum7th     (sums[6]),
    .iFirSum8th     (sums[7]),
    .iFirSum9th     (sums[8]),
    .iFirSum10th    (sums[9]),
    .iFirSum11th    (sums[10]),
    .iFirSum12th    (sums[11]),
    .oFirOut        (oFirOut),
    .oFirValid      (oFirValid),
    .oBusy          (oBusy),
    .oOverrun       (oOverrun)
  );

  task automatic chk(input string name, input integer act, input integer exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: full-precision dot product, floor divide by 16, clamp to 16 bits.
  function automatic int ref_result();
    longint a = 0;
    for (int k = 0; k < 12; k++) a += longint'(sums[k]) * longint'(COEF[k]);
    a = a >>> 4;
    if (a > 32767) return 32767;
    if (a < -32768) return -32768;
    return int'(a);
  endfunction

  // Model: m_phase counts edges since an accepted trigger (0 = free).
  // The sums are taken one edge after the trigger; the result appears
  // 14 edges after it; the unit is busy until then.
  int m_phase = 0;
  int m_res = 0;
  int m_out = 0;
  bit m_valid = 1'b0;
  bit m_over = 1'b0;

  always @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      m_phase <= 0;
      m_res   <= 0;
      m_out   <= 0;
      m_valid <= 1'b0;
      m_over  <= 1'b0;
    end else begin
      m_valid <= 1'b0;
      if (m_phase == 0) begin
        if (iEnSample_600k && iEnDelay) m_phase <= 1;
      end else begin
        if (iEnSample_600k && iEnDelay) m_over <= 1'b1;
        if (m_phase == 1) m_res <= ref_result();
        if (m_phase == 14) begin
          m_out   <= m_res;
          m_valid <= 1'b1;
          m_phase <= 0;
        end else begin
          m_phase <= m_phase + 1;
        end
      end
    end
  end

  always @(negedge iClk_12M) begin
    if (cmp_en) begin
      chk("cyc_out", oFirOut, m_out);
      chk("cyc_valid", oFirValid, m_valid);
      chk("cyc_busy", oBusy, (m_phase != 0) ? 1 : 0);
      chk("cyc_overrun", oOverrun, m_over);
      if (oFirValid === 1'b1) nvalid++;
    end
  end

  task automatic rand_sums();
    for (int k = 0; k < 12; k++) sums[k] = 16'($urandom);
  endtask

  // Trigger with garbage on the inputs, then present s_new for the snapshot
  // edge; check the 15-cycle latency and the hand-computed result.
  task automatic run_one(input string name, input logic signed [15:0] s_new [12],
                         input int exp_lit);
    int n;
    @(negedge iClk_12M);
    rand_sums();
    iEnSample_600k = 1'b1;
    @(negedge iClk_12M);
    iEnSample_600k = 1'b0;
    for (int k = 0; k < 12; k++) sums[k] = s_new[k];
    n = 1;
    while (oFirValid !== 1'b1 && n < 40) begin
      @(negedge iClk_12M);
      n++;
    end
    chk({name, "_latency"}, n, 15);
    chk({name, "_out"}, oFirOut, exp_lit);
    repeat (3) @(negedge iClk_12M);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic signed [15:0] v [12];
    int sweep_exp [12];
    int v0, n;

    sweep_exp = '{6, 20, 37, 26, -42, -148, -295, -449, -588, -695, -765, -800};
    for (int k = 0; k < 12; k++) sums[k] = '0;
    #1 iRsn = 1'b0;
    cmp_en = 1'b1;
    repeat (3) @(negedge iClk_12M);
    chk("rst_out", oFirOut, 0);
    chk("rst_valid", oFirValid, 0);
    chk("rst_busy", oBusy, 0);
    chk("rst_overrun", oOverrun, 0);
    #2 iRsn = 1'b1;
    repeat (2) @(negedge iClk_12M);

    // Impulse on tap 1: -50 >>> 4 floors to -4.
    for (int k = 0; k < 12; k++) v[k] = '0;
    v[0] = 16'sd1;
    run_one("impulse", v, -4);

    // Per-tap sweep with -2.
    for (int t = 0; t < 12; t++) begin
      for (int k = 0; k < 12; k++) v[k] = '0;
      v[t] = -16'sd2;
      run_one($sformatf("sweep%0d", t), v, sweep_exp[t]);
    end

    // Saturation both ways.
    for (int k = 0; k < 12; k++) v[k] = (COEF[k] > 0) ? 16'sd32767 : -16'sd32767;
    run_one("sat_pos", v, 32767);
    for (int k = 0; k < 12; k++) v[k] = (COEF[k] > 0) ? -16'sd32767 : 16'sd32767;
    run_one("sat_neg", v, -32768);

    // Delay-chain enable low: strobe alone must not start anything.
    v0 = nvalid;
    iEnDelay = 1'b0;
    @(negedge iClk_12M) iEnSample_600k = 1'b1;
    @(negedge iClk_12M) iEnSample_600k = 1'b0;
    repeat (20) @(negedge iClk_12M);
    chk("endelay_gate_count", nvalid - v0, 0);
    iEnDelay = 1'b1;

    // Overrun: second trigger five edges after the first.
    v0 = nvalid;
    @(negedge iClk_12M);
    rand_sums();
    iEnSample_600k = 1'b1;
    @(negedge iClk_12M);
    iEnSample_600k = 1'b0;
    for (int k = 0; k < 12; k++) sums[k] = '0;
    sums[0] = 16'sd16;
    repeat (4) @(negedge iClk_12M);
    iEnSample_600k = 1'b1;
    rand_sums();
    @(negedge iClk_12M);
    iEnSample_600k = 1'b0;
    repeat (25) @(negedge iClk_12M);
    chk("overrun_count", nvalid - v0, 1);
    chk("overrun_out", oFirOut, -50);
    chk("overrun_flag", oOverrun, 1);

    // Reset abort in MAC cycle 6.
    v0 = nvalid;
    @(negedge iClk_12M);
    iEnSample_600k = 1'b1;
    @(negedge iClk_12M);
    iEnSample_600k = 1'b0;
    repeat (5) @(negedge iClk_12M);
    #2 iRsn = 1'b0;
    #1;
    chk("abort_out", oFirOut, 0);
    chk("abort_valid", oFirValid, 0);
    chk("abort_busy", oBusy, 0);
    chk("abort_overrun", oOverrun, 0);
    repeat (2) @(negedge iClk_12M);
    #2 iRsn = 1'b1;
    repeat (20) @(negedge iClk_12M);
    chk("abort_no_valid", nvalid - v0, 0);
    for (int k = 0; k < 12; k++) v[k] = '0;
    v[0] = 16'sd1;
    run_one("post_abort", v, -4);

    // Trigger held through the DONE cycle and the first IDLE cycle.
    v0 = nvalid;
    for (int k = 0; k < 12; k++) sums[k] = '0;
    sums[11] = 16'sd16;
    @(negedge iClk_12M) iEnSample_600k = 1'b1;
    @(negedge iClk_12M) iEnSample_600k = 1'b0;
    repeat (13) @(negedge iClk_12M);
    iEnSample_600k = 1'b1;
    @(negedge iClk_12M);
    chk("done_trig_overrun", oOverrun, 1);
    chk("done_valid", oFirValid, 1);
    chk("done_out", oFirOut, 6400);
    @(negedge iClk_12M);
    iEnSample_600k = 1'b0;
    chk("idle_accept_busy", oBusy, 1);
    n = 1;
    while (oFirValid !== 1'b1 && n < 40) begin
      @(negedge iClk_12M);
      n++;
    end
    chk("idle_accept_latency", n, 15);
    chk("idle_accept_out", oFirOut, 6400);
    repeat (3) @(negedge iClk_12M);
    chk("boundary_count", nvalid - v0, 2);

    // Back-to-back at the sample rate with inputs changing every cycle.
    #2 iRsn = 1'b0;
    @(negedge iClk_12M);
    #2 iRsn = 1'b1;
    repeat (2) @(negedge iClk_12M);
    v0 = nvalid;
    for (int i = 0; i < 50; i++) begin
      @(negedge iClk_12M);
      iEnSample_600k = 1'b1;
      rand_sums();
      @(negedge iClk_12M);
      iEnSample_600k = 1'b0;
      rand_sums();
      for (int j = 0; j < 18; j++) begin
        @(negedge iClk_12M);
        rand_sums();
      end
    end
    repeat (5) @(negedge iClk_12M);
    chk("b2b_count", nvalid - v0, 50);
    chk("b2b_overrun", oOverrun, 0);

    // Idle hold.
    repeat (30) @(negedge iClk_12M);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
